// File: rtl/invmix_roundkey_ctrl.sv
// ============================================================================
// Module   : invmix_roundkey_ctrl
// Purpose  : Converts stored AES encryption round keys into decryption keys.
//            Keys are written in reverse order, and the inner keys are passed
//            through an external InvMixColumns block.
// Option   : INVMIX_ZEROIZE_EN clears the key register after each write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module invmix_roundkey_ctrl #(
  parameter int NUM_ROUNDS = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         rk_rd_en,
  output logic [3:0]   rk_rd_addr,
  input  logic [127:0] rk_rd_data,
  output logic [127:0] imc_state_in,
  input  logic [127:0] imc_state_out,
  output logic         dk_wr_en,
  output logic [3:0]   dk_wr_addr,
  output logic [127:0] dk_wr_data
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] rk_q, rk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      rk_q    <= 128'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rk_q    <= rk_d;
    end
  end

  assign imc_state_in = rk_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rk_d       = rk_q;
    busy       = 1'b0;
    done       = 1'b0;
    rk_rd_en   = 1'b0;
    rk_rd_addr = 4'd0;
    dk_wr_en   = 1'b0;
    dk_wr_addr = 4'd0;
    dk_wr_data = 128'd0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          idx_d   = 4'd0;
        end
      end

      READ: begin
        busy       = 1'b1;
        rk_rd_en   = 1'b1;
        rk_rd_addr = LAST_IDX - idx_q;
        state_d    = CAPTURE;
      end

      CAPTURE: begin
        busy    = 1'b1;
        rk_d    = rk_rd_data;
        state_d = WRITE;
      end

      WRITE: begin
        busy       = 1'b1;
        dk_wr_en   = 1'b1;
        dk_wr_addr = idx_q;
        // First and last decryption keys skip InvMixColumns
        if ((idx_q == 4'd0) || (idx_q == LAST_IDX)) begin
          dk_wr_data = rk_q;
        end else begin
          dk_wr_data = imc_state_out;
        end
`ifdef INVMIX_ZEROIZE_EN
        rk_d = 128'd0;
`endif
        if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = READ;
        end
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_invmix_roundkey_ctrl.sv
// ============================================================================
// Module   : tb_invmix_roundkey_ctrl
// Purpose  : Self-checking bench for invmix_roundkey_ctrl with a behavioural
//            key RAM, InvMixColumns model and write monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_invmix_roundkey_ctrl;

  localparam int NR  = 14;
  localparam int LAT = 3 * (NR + 1) + 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_addr;
  logic [127:0] rk_rd_data;
  logic [127:0] imc_state_in;
  logic [127:0] imc_state_out;
  logic         dk_wr_en;
  logic [3:0]   dk_wr_addr;
  logic [127:0] dk_wr_data;

  invmix_roundkey_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .rk_rd_en      (rk_rd_en),
    .rk_rd_addr    (rk_rd_addr),
    .rk_rd_data    (rk_rd_data),
    .imc_state_in  (imc_state_in),
    .imc_state_out (imc_state_out),
    .dk_wr_en      (dk_wr_en),
    .dk_wr_addr    (dk_wr_addr),
    .dk_wr_data    (dk_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) arithmetic for the InvMixColumns reference
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
            gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
            gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
            gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14)};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return {inv_col(s[127:96]), inv_col(s[95:64]), inv_col(s[63:32]), inv_col(s[31:0])};
  endfunction

  assign imc_state_out = inv_mix(imc_state_in);

  // Encryption-key RAM: one-cycle read latency
  logic [127:0] ek [0:15];
  always @(posedge clk) begin
    if (rk_rd_en) rk_rd_data <= ek[rk_rd_addr];
  end

  // Write/protocol monitor, sampled mid-cycle
  logic [127:0] dk [0:15];
  int           wr_cnt [0:15];
  int           n_wr;
  int           n_done;
  int           proto_err;

  always @(negedge clk) begin
    if (!rk_rd_en && rk_rd_addr != 4'd0) proto_err++;
    if (!dk_wr_en && (dk_wr_addr != 4'd0 || dk_wr_data != 128'd0)) proto_err++;
    if (rk_rd_en && dk_wr_en) proto_err++;
    if (done && busy) proto_err++;
`ifdef INVMIX_ZEROIZE_EN
    if (rk_rd_en && imc_state_in != 128'd0) proto_err++;
`endif
    if (dk_wr_en) begin
      dk[dk_wr_addr] = dk_wr_data;
      wr_cnt[dk_wr_addr]++;
      n_wr++;
    end
    if (done) n_done++;
  end

  int total;
  int bad;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 16; k++) begin
      wr_cnt[k] = 0;
      dk[k]     = 128'd0;
    end
    n_wr      = 0;
    n_done    = 0;
    proto_err = 0;
  endtask

  task automatic run_conv(input bit hold, output int lat, output int bcyc);
    clear_mon();
    start = 1'b1;
    lat   = 0;
    bcyc  = 0;
    do begin
      tick();
      lat++;
      if (!hold) start = 1'b0;
      if (busy) bcyc++;
    end while (!done && lat < 200);
    start = 1'b0;
    tick();
    tick();
  endtask

  // Reference: decryption key j is encryption key NR-j, inner keys InvMixColumns'd
  task automatic check_keys(input string tag);
    int once;
    once = 1;
    for (int j = 0; j <= NR; j++) begin
      logic [127:0] exp;
      exp = (j == 0 || j == NR) ? ek[NR - j] : inv_mix(ek[NR - j]);
      check($sformatf("%s_dk%0d", tag, j), dk[j], exp);
      if (wr_cnt[j] != 1) once = 0;
    end
    check({tag, "_each_once"}, 128'(once), 128'd1);
    check({tag, "_writes"}, 128'(n_wr), 128'(NR + 1));
    check({tag, "_done_pulses"}, 128'(n_done), 128'd1);
    check({tag, "_protocol"}, 128'(proto_err), 128'd0);
`ifdef INVMIX_ZEROIZE_EN
    check({tag, "_imc_after_done"}, imc_state_in, 128'd0);
`else
    check({tag, "_imc_after_done"}, imc_state_in, ek[0]);
`endif
  endtask

  int lat;
  int bcyc;
  int snap;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 16; k++) ek[k] = 128'd0;
    clear_mon();

    // Reset with start held high
    tick();
    tick();
    check("rst_outs", {busy, done, rk_rd_en, dk_wr_en, rk_rd_addr, dk_wr_addr},
          128'd0);
    check("rst_wdata", dk_wr_data, 128'd0);
    check("rst_imc", imc_state_in, 128'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    tick();
    check("rst_idle_busy", 128'(busy), 128'd0);
    check("rst_no_writes", 128'(n_wr), 128'd0);

    // Equal-byte keys map straight through in reverse order
    for (int k = 0; k <= NR; k++) ek[k] = {16{8'(k)}};
    run_conv(1'b0, lat, bcyc);
    check("map_latency", 128'(lat), 128'(LAT));
    check("map_busy_cycles", 128'(bcyc), 128'(LAT - 1));
    check_keys("map");
    for (int j = 0; j <= NR; j++) check($sformatf("map_const%0d", j), dk[j], {16{8'(NR - j)}});

    // Random keys plus a known InvMixColumns answer
    for (int k = 0; k <= NR; k++) ek[k] = {$urandom, $urandom, $urandom, $urandom};
    ek[7] = {4{32'h8e4da1bc}};
    run_conv(1'b0, lat, bcyc);
    check("kat_latency", 128'(lat), 128'(LAT));
    check("kat_dk7", dk[7], {4{32'hdb135345}});
    check("kat_dk0", dk[0], ek[NR]);
    check("kat_dk14", dk[NR], ek[0]);
    check_keys("kat");

    // Start held high throughout a conversion
    for (int k = 0; k <= NR; k++) ek[k] = {$urandom, $urandom, $urandom, $urandom};
    run_conv(1'b1, lat, bcyc);
    check("hold_latency", 128'(lat), 128'(LAT));
    check_keys("hold");
    repeat (5) tick();
    check("hold_no_restart", 128'(n_wr), 128'(NR + 1));

    // Reset during cycle 20 of a conversion
    for (int k = 0; k <= NR; k++) ek[k] = {$urandom, $urandom, $urandom, $urandom};
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    snap = n_wr;
    check("mid_pre_writes", 128'(snap), 128'd6);
    check("mid_after_rst", {busy, done, rk_rd_en, dk_wr_en}, 128'd0);
    check("mid_imc_cleared", imc_state_in, 128'd0);
    repeat (50) tick();
    check("mid_no_more_writes", 128'(n_wr), 128'(snap));
    run_conv(1'b0, lat, bcyc);
    check("mid_restart_latency", 128'(lat), 128'(LAT));
    check_keys("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
